sram_port_arbiter: RTL

//  Shares one SRAM-like memory port between the IF-stage instruction requester (M0) and the
//  EXE-stage data requester (M1). Fixed data priority plus an anti-starvation counter; one

---
 rtl/sram_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between instruction and data requesters
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_req,
    output logic              sram_wr,
    output logic [3:0]        sram_wstrb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_addr_ok,
    input  logic              sram_data_ok,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;        // 0 = instruction side, 1 = data side
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              grant_any;
    logic              grant_data;
    logic              lat_wr;
    logic [3:0]        lat_wstrb;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Grant decision: data wins unless inst has been passed over STARVE_LIMIT times in a row
    always_comb begin
        grant_any  = inst_req | data_req;
        grant_data = data_req & (~inst_req | (starve_cnt != CNT_MAX));
        starve_nxt = starve_cnt;
        if (grant_any) begin
            if (!grant_data) begin
                starve_nxt = '0;
            end else if (inst_req) begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one transaction in flight, IDLE -> ADDR -> DATA -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any)    state_nxt = S_ADDR;
            S_ADDR:  if (sram_addr_ok) state_nxt = S_DATA;
            S_DATA:  if (sram_data_ok) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner's fields at grant so later changes on the master side are ignored
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= 1'b0;
            starve_cnt <= '0;
            lat_wr     <= 1'b0;
            lat_wstrb  <= 4'h0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state == S_IDLE && grant_any) begin
            owner      <= grant_data;
            starve_cnt <= starve_nxt;
            if (grant_data) begin
                lat_wr    <= data_wr;
                lat_wstrb <= data_wstrb;
                lat_addr  <= data_addr;
                lat_wdata <= data_wdata;
            end else begin
                lat_wr    <= 1'b0;
                lat_wstrb <= 4'h0;
                lat_addr  <= inst_addr;
                lat_wdata <= '0;
            end
        end
    end

    // Outputs: downstream fields from latches, handshakes steered to the owner only
    always_comb begin
        sram_req     = 1'b0;
        sram_wr      = lat_wr;
        sram_wstrb   = lat_wstrb;
        sram_addr    = lat_addr;
        sram_wdata   = lat_wdata;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        busy         = (state != S_IDLE);
        case (state)
            S_ADDR: begin
                sram_req = 1'b1;
                if (sram_addr_ok) begin
                    if (owner) data_addr_ok = 1'b1;
                    else       inst_addr_ok = 1'b1;
                end
            end
            S_DATA: begin
                if (sram_data_ok) begin
                    if (owner) begin
                        data_data_ok = 1'b1;
                        data_rdata   = sram_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = sram_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
